// File: rtl/entropy_enc_pkg.sv
// Shared definitions for the entropy-encoder bitstream back end.
//   state_e    : carry/emission controller FSM states
//   BYTE_FF    : the byte value that can be pushed over by a later carry
//   CARRY_BIT  : position of the carry flag inside a pre-bitstream word
//   FLAG_*     : meaning of the per-beat word-count flag
//   run_byte() : byte value emitted for each deferred 0xFF once its carry is known
package entropy_enc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_EMIT_HELD,
    S_EMIT_RUN,
    S_FLUSH_HELD,
    S_FLUSH_RUN,
    S_DONE
  } state_e;

  localparam logic [7:0] BYTE_FF      = 8'hFF;
  localparam int         CARRY_BIT    = 8;
  localparam logic [1:0] FLAG_NONE    = 2'd0;
  localparam logic [1:0] FLAG_ONE     = 2'd1;
  localparam logic [1:0] FLAG_TWO     = 2'd2;
  localparam logic [1:0] FLAG_ILLEGAL = 2'd3;

  // A carry turns every deferred 0xFF into 0x00; without one they stay 0xFF.
  function automatic logic [7:0] run_byte(input logic carry);
    return carry ? 8'h00 : BYTE_FF;
  endfunction

endpackage

// File: rtl/bitstream_carry_ctrl_ff_run_counter.sv
// ff_run_counter: length of the current run of deferred 0xFF bytes.
//   clk, reset : clock, synchronous active-high reset
//   inc        : another 0xFF joined the run (saturates at 2**RUN_WIDTH-1)
//   dec        : one deferred byte was handed to the output register
//   clr        : drop the run entirely
//   is_zero    : no deferred bytes outstanding
//   ovf        : inc requested while already saturated (run overflow)
module ff_run_counter #(
  parameter int RUN_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic is_zero,
  output logic ovf
);

  logic [RUN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 at_max;

  assign at_max  = &cnt_q;
  assign is_zero = (cnt_q == '0);
  assign ovf     = inc & at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (!at_max) cnt_d = cnt_q + 1'b1;
    end else if (dec && !is_zero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bitstream_carry_ctrl.sv
// bitstream_carry_ctrl: carry propagation and byte emission after renormalisation.
// Takes 0..2 pre-bitstream words per beat, defers 0xFF runs until a later carry
// resolves them, and emits final bytes one per cycle on a valid/ready port.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : input beat handshake (ready only while idle)
//   in_flag              : 0 none, 1 bit_1, 2 bit_1 then bit_2, 3 illegal
//   in_bit_1/in_bit_2    : words, bit 8 carry, bits 7:0 byte
//   flush                : end-of-frame request, sampled while in_ready=1
//   out_valid/out_ready  : output byte handshake, out_byte held until taken
//   done                 : one-cycle pulse when a flush has completed
//   err                  : sticky protocol/overflow error
//   byte_count           : transferred bytes since last done (BITSTREAM_COUNT_EN only)
// Build option: define BITSTREAM_COUNT_EN to add the byte_count output.
module bitstream_carry_ctrl
  import entropy_enc_pkg::*;
#(
  parameter int RANGE_WIDTH = 16,
  parameter int RUN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_flag,
  input  logic [RANGE_WIDTH-1:0] in_bit_1,
  input  logic [RANGE_WIDTH-1:0] in_bit_2,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   done,
  output logic                   err
`ifdef BITSTREAM_COUNT_EN
  ,
  output logic [31:0]            byte_count
`endif
);

  state_e     state_q, state_d;
  logic [8:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0] slot_cnt_q, slot_cnt_d;
  logic [7:0] held_q, held_d;
  logic       held_valid_q, held_valid_d;
  logic [7:0] cur_b_q, cur_b_d;
  logic       cur_c_q, cur_c_d;
  logic       flush_pend_q, flush_pend_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic       err_q, err_d;

  logic       run_inc, run_dec, run_clr, run_zero, run_ovf;
  logic       xfer, advance, finish_word, beat;
  logic       c_w;
  logic [7:0] b_w;
  logic       unused_hi;

  assign unused_hi = ^{in_bit_1[RANGE_WIDTH-1:9], in_bit_2[RANGE_WIDTH-1:9]};

  ff_run_counter #(.RUN_WIDTH(RUN_WIDTH)) u_run (
    .clk     (clk),
    .reset   (reset),
    .inc     (run_inc),
    .dec     (run_dec),
    .clr     (run_clr),
    .is_zero (run_zero),
    .ovf     (run_ovf)
  );

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign done      = (state_q == S_DONE);
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign err       = err_q;
  assign xfer      = out_valid_q & out_ready;
  assign c_w       = slot0_q[CARRY_BIT];
  assign b_w       = slot0_q[7:0];

  always_comb begin
    state_d      = state_q;
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    slot_cnt_d   = slot_cnt_q;
    held_d       = held_q;
    held_valid_d = held_valid_q;
    cur_b_d      = cur_b_q;
    cur_c_d      = cur_c_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_byte_d   = out_byte_q;
    err_d        = err_q;
    run_inc      = 1'b0;
    run_dec      = 1'b0;
    run_clr      = 1'b0;
    advance      = 1'b0;
    finish_word  = 1'b0;
    beat         = in_valid && (in_flag == FLAG_ONE || in_flag == FLAG_TWO);

    case (state_q)
      S_IDLE: begin
        if (in_ready) begin
          if (in_valid && in_flag == FLAG_ILLEGAL) err_d = 1'b1;
          if (beat) begin
            slot0_d      = in_bit_1[8:0];
            slot1_d      = in_bit_2[8:0];
            slot_cnt_d   = (in_flag == FLAG_TWO) ? 2'd2 : 2'd1;
            flush_pend_d = flush;
            state_d      = S_EVAL;
          end else if (flush) begin
            // Nothing buffered: skip straight to done so it pulses next cycle.
            state_d = (!held_valid_q && run_zero) ? S_DONE : S_FLUSH_HELD;
          end
        end
      end

      S_EVAL: begin
        if (!c_w && b_w == BYTE_FF) begin
          run_inc = 1'b1;
          if (run_ovf) err_d = 1'b1;
          advance = 1'b1;
        end else begin
          cur_b_d = b_w;
          cur_c_d = c_w;
          if (!held_valid_q) begin
            if (c_w) err_d = 1'b1;
            if (run_zero) begin
              held_d       = b_w;
              held_valid_d = 1'b1;
              advance      = 1'b1;
            end else begin
              out_valid_d = 1'b1;
              out_byte_d  = run_byte(c_w);
              run_dec     = 1'b1;
              state_d     = S_EMIT_RUN;
            end
          end else begin
            // 0xFF + carry would need a carry into an already-emitted byte.
            if (c_w && held_q == BYTE_FF) err_d = 1'b1;
            out_valid_d = 1'b1;
            out_byte_d  = held_q + {7'd0, c_w};
            state_d     = S_EMIT_HELD;
          end
        end
      end

      S_EMIT_HELD, S_EMIT_RUN: begin
        if (xfer) begin
          if (!run_zero) begin
            out_byte_d = run_byte(cur_c_q);
            run_dec    = 1'b1;
            state_d    = S_EMIT_RUN;
          end else begin
            out_valid_d = 1'b0;
            finish_word = 1'b1;
          end
        end
      end

      S_FLUSH_HELD: begin
        if (!out_valid_q) begin
          if (held_valid_q) begin
            out_valid_d  = 1'b1;
            out_byte_d   = held_q;
            held_valid_d = 1'b0;
          end else if (!run_zero) begin
            out_valid_d = 1'b1;
            out_byte_d  = BYTE_FF;
            run_dec     = 1'b1;
            state_d     = S_FLUSH_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else if (xfer) begin
          if (!run_zero) begin
            out_byte_d = BYTE_FF;
            run_dec    = 1'b1;
            state_d    = S_FLUSH_RUN;
          end else begin
            out_valid_d = 1'b0;
            state_d     = S_DONE;
          end
        end
      end

      S_FLUSH_RUN: begin
        if (xfer) begin
          if (!run_zero) begin
            out_byte_d = BYTE_FF;
            run_dec    = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = S_DONE;
          end
        end
      end

      S_DONE: begin
        held_valid_d = 1'b0;
        run_clr      = 1'b1;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // The resolved word's byte becomes the new held byte.
    if (finish_word) begin
      held_d       = cur_b_q;
      held_valid_d = 1'b1;
      advance      = 1'b1;
    end

    if (advance) begin
      if (slot_cnt_q == 2'd2) begin
        slot0_d    = slot1_q;
        slot_cnt_d = 2'd1;
        state_d    = S_EVAL;
      end else begin
        slot_cnt_d = 2'd0;
        if (flush_pend_q) begin
          flush_pend_d = 1'b0;
          state_d      = S_FLUSH_HELD;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      slot_cnt_q   <= 2'd0;
      held_q       <= 8'd0;
      held_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
    cur_b_q <= cur_b_d;
    cur_c_q <= cur_c_d;
  end

`ifdef BITSTREAM_COUNT_EN
  logic [31:0] byte_count_q, byte_count_d;

  always_comb begin
    byte_count_d = byte_count_q + {31'd0, xfer};
    if (state_q == S_DONE) byte_count_d = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) byte_count_q <= 32'd0;
    else       byte_count_q <= byte_count_d;
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_bitstream_carry_ctrl.sv
// Self-checking bench for bitstream_carry_ctrl: directed frames plus randomized
// frames with random backpressure, checked against a list-based reference model.
module tb_bitstream_carry_ctrl;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready, done, err;
  logic [1:0]  in_flag;
  logic [15:0] in_bit_1, in_bit_2;
  logic [7:0]  out_byte;
`ifdef BITSTREAM_COUNT_EN
  logic [31:0] byte_count;
  logic [31:0] bc_at_done;
`endif

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [7:0]  got[$];

  always #5 clk = ~clk;

  bitstream_carry_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flag   (in_flag),
    .in_bit_1  (in_bit_1),
    .in_bit_2  (in_bit_2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .done      (done),
    .err       (err)
`ifdef BITSTREAM_COUNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  // Record every accepted byte and every done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got.push_back(out_byte);
      if (done) begin
        done_cnt++;
`ifdef BITSTREAM_COUNT_EN
        bc_at_done = byte_count;
`endif
      end
    end
  end

  // Reference: walk the word list resolving each 0xFF run when a non-0xFF word arrives.
  function automatic void model(input logic [8:0] w[$], output logic [7:0] q[$], output bit e);
    bit         hv;
    bit         c;
    logic [7:0] h, b;
    int         run;
    hv = 0; h = 0; run = 0; e = 0; q = {};
    foreach (w[i]) begin
      c = w[i][8];
      b = w[i][7:0];
      if (!c && b == 8'hFF) begin
        if (run == 255) e = 1;
        else run++;
      end else begin
        if (!hv) begin
          if (c) e = 1;
        end else begin
          if (h == 8'hFF && c) e = 1;
          q.push_back(h + {7'd0, c});
        end
        repeat (run) q.push_back(c ? 8'h00 : 8'hFF);
        run = 0;
        h = b;
        hv = 1;
      end
    end
    if (hv) q.push_back(h);
    repeat (run) q.push_back(8'hFF);
  endfunction

  task automatic do_reset();
    reset = 1; in_valid = 0; flush = 0; in_flag = 0; in_bit_1 = 0; in_bit_2 = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    got.delete();
  endtask

  task automatic send_beat(input logic v, input logic [1:0] f, input logic [8:0] w1,
                           input logic [8:0] w2, input logic fl, inout int to);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    in_valid = v; in_flag = f; flush = fl;
    in_bit_1 = {7'($urandom), w1};
    in_bit_2 = {7'($urandom), w2};
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) to++;
    @(posedge clk);
    #1 in_valid = 0; flush = 0;
  endtask

  task automatic wait_done(input int start, inout int to);
    bit ok;
    ok = 0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      if (done_cnt != start) begin ok = 1; break; end
    end
    if (!ok) to++;
  endtask

  task automatic drive_frame(input logic [8:0] w[$], input bit fl_last, inout int to);
    int i, n, start;
    bit two, last;
    i = 0; n = w.size(); start = done_cnt;
    while (i < n) begin
      two  = (n - i >= 2) && ($urandom_range(0, 1) == 1);
      last = two ? (i + 2 == n) : (i + 1 == n);
      send_beat(1, two ? 2'd2 : 2'd1, w[i], two ? w[i+1] : 9'h0, last && fl_last, to);
      i += two ? 2 : 1;
    end
    if (!fl_last) send_beat(0, 2'd0, 9'h0, 9'h0, 1, to);
    wait_done(start, to);
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 1; in_flag = 2'd1; flush = 1; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_byte !== 8'h00) begin bad++; $display("FAIL reset_out_byte got=%h exp=00", out_byte); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    do_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int to, start;
    logic [7:0] exp[$];
    to = 0;
    do_reset();
    start = done_cnt;
    send_beat(1, 2'd2, 9'h012, 9'h034, 0, to);
    send_beat(0, 2'd0, 9'h0, 9'h0, 1, to);
    wait_done(start, to);
    repeat (10) @(posedge clk);
    exp = '{8'h12, 8'h34};
    total++; if (to != 0) begin bad++; $display("FAIL basic_timeout got=%0d exp=0", to); end
    total++; if (got.size() != exp.size()) begin bad++; $display("FAIL basic_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL basic_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
    total++; if (done_cnt - start != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - start); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
  endtask

  task automatic test_carry();
    int to;
    logic [8:0] w[$];
    logic [7:0] exp[$];
    to = 0;
    do_reset();
    w = '{9'h012, 9'h0FF, 9'h0FF, 9'h105};
    drive_frame(w, 0, to);
    exp = '{8'h13, 8'h00, 8'h00, 8'h05};
    total++; if (to != 0) begin bad++; $display("FAIL carry_timeout got=%0d exp=0", to); end
    total++; if (got.size() != exp.size()) begin bad++; $display("FAIL carry_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL carry_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL carry_err got=%b exp=0", err); end
  endtask

  task automatic test_no_carry();
    int to;
    logic [8:0] w[$];
    logic [7:0] exp[$];
    to = 0;
    do_reset();
    w = '{9'h012, 9'h0FF, 9'h007};
    drive_frame(w, 0, to);
    exp = '{8'h12, 8'hFF, 8'h07};
    total++; if (to != 0) begin bad++; $display("FAIL nocarry_timeout got=%0d exp=0", to); end
    total++; if (got.size() != exp.size()) begin bad++; $display("FAIL nocarry_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL nocarry_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int to;
    bit seen;
    logic [8:0] w[$];
    logic [7:0] exp[$];
    to = 0; seen = 0;
    do_reset();
    w = '{9'h012, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h101};
    exp = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    fork
      drive_frame(w, 0, to);
      begin
        for (int k = 0; k < 2000; k++) begin
          @(posedge clk);
          if (got.size() >= 2) begin seen = 1; break; end
        end
        #1 out_ready = 0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", j, out_valid); end
          total++; if (out_byte !== 8'h00) begin bad++; $display("FAIL stall_byte[%0d] got=%h exp=00", j, out_byte); end
          total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", j, in_ready); end
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    total++; if (!seen || to != 0) begin bad++; $display("FAIL stall_timeout got=%0d exp=0", to + (seen ? 0 : 1)); end
    total++; if (got.size() != exp.size()) begin bad++; $display("FAIL stall_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL stall_order[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int to, start;
    bit ok;
    to = 0; ok = 0;
    do_reset();
    out_ready = 0;
    send_beat(1, 2'd2, 9'h012, 9'h0FF, 0, to);
    send_beat(1, 2'd2, 9'h0FF, 9'h101, 0, to);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    total++; if (!ok || out_valid !== 1'b1 || out_byte !== 8'h00) begin
      bad++; $display("FAIL midrun_setup got=%b/%h exp=1/00", out_valid, out_byte);
    end
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_valid_after_reset got=%b exp=0", out_valid); end
    got.delete();
    out_ready = 1;
    start = done_cnt;
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_flush_done got=%b exp=1", done); end
    repeat (6) @(posedge clk);
    total++; if (got.size() != 0) begin bad++; $display("FAIL empty_flush_bytes got=%0d exp=0", got.size()); end
    total++; if (done_cnt - start != 1) begin bad++; $display("FAIL empty_flush_pulses got=%0d exp=1", done_cnt - start); end
    total++; if (to != 0) begin bad++; $display("FAIL midrun_timeout got=%0d exp=0", to); end
  endtask

  task automatic test_err();
    int to;
    bit e;
    logic [8:0] w[$];
    logic [7:0] exp[$];
    to = 0;
    do_reset();
    send_beat(1, 2'd1, 9'h180, 9'h0, 0, to);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_carry_no_held got=%b exp=1", err); end
    w = '{9'h012};
    drive_frame(w, 0, to);
    w = '{9'h180, 9'h012};
    model(w, exp, e);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    total++; if (got.size() != exp.size()) begin bad++; $display("FAIL err_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL err_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
    // held 0xFF plus carry
    do_reset();
    w = '{9'h034, 9'h1FF, 9'h101};
    drive_frame(w, 1, to);
    model(w, exp, e);
    total++; if (err !== e) begin bad++; $display("FAIL err_held_ff got=%b exp=%b", err, e); end
    total++; if (got.size() != exp.size()) begin bad++; $display("FAIL err_ff_len got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL err_ff_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
    // illegal flag
    do_reset();
    send_beat(1, 2'd3, 9'h012, 9'h034, 0, to);
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_flag3 got=%b exp=1", err); end
    total++; if (got.size() != 0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL flag3_bytes got=%0d/%b exp=0/0", got.size(), out_valid);
    end
    total++; if (to != 0) begin bad++; $display("FAIL err_timeout got=%0d exp=0", to); end
  endtask

  task automatic test_overflow();
    int to;
    bit e;
    logic [8:0] w[$];
    logic [7:0] exp[$];
    to = 0;
    do_reset();
    w = '{9'h034};
    repeat (260) w.push_back(9'h0FF);
    w.push_back(9'h105);
    drive_frame(w, 0, to);
    model(w, exp, e);
    total++; if (to != 0) begin bad++; $display("FAIL ovf_timeout got=%0d exp=0", to); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", err); end
    total++; if (got.size() != 257) begin bad++; $display("FAIL ovf_len got=%0d exp=257", got.size()); end
    foreach (exp[i]) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL ovf_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    int to, n, r;
    bit e, stop;
    logic [8:0] w[$];
    logic [7:0] exp[$];
    for (int f = 0; f < 8; f++) begin
      to = 0; stop = 0;
      do_reset();
      w = {};
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        w.push_back({($urandom_range(0, 4) == 0), (r < 4) ? 8'hFF : 8'($urandom)});
      end
      fork
        begin
          drive_frame(w, ($urandom_range(0, 1) == 1), to);
          stop = 1;
        end
        while (!stop) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      join
      out_ready = 1;
      model(w, exp, e);
      total++; if (to != 0) begin bad++; $display("FAIL rand%0d_timeout got=%0d exp=0", f, to); end
      total++; if (err !== e) begin bad++; $display("FAIL rand%0d_err got=%b exp=%b", f, err, e); end
      total++; if (got.size() != exp.size()) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", f, got.size(), exp.size()); end
      foreach (exp[i]) begin
        total++;
        if (i >= got.size() || got[i] !== exp[i]) begin
          bad++; $display("FAIL rand%0d_byte[%0d] got=%h exp=%h", f, i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
        end
      end
    end
  endtask

`ifdef BITSTREAM_COUNT_EN
  task automatic test_count();
    int to;
    logic [8:0] w[$];
    to = 0;
    do_reset();
    bc_at_done = 32'hFFFF_FFFF;
    w = '{9'h012, 9'h0FF, 9'h0FF, 9'h105};
    drive_frame(w, 0, to);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bc_at_done !== 32'd4) begin bad++; $display("FAIL count_at_done got=%0d exp=4", bc_at_done); end
    total++; if (byte_count !== 32'd0) begin bad++; $display("FAIL count_after_done got=%0d exp=0", byte_count); end
    total++; if (to != 0) begin bad++; $display("FAIL count_timeout got=%0d exp=0", to); end
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_no_carry();
    test_backpressure();
    test_reset_mid();
    test_err();
    test_overflow();
    test_random();
`ifdef BITSTREAM_COUNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
